keccak_digest_reader: RTL and testbench
=======================================

KECCAK_DIGEST_READER -- requirements
Module: keccak_digest_reader

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: alu_op  input  5  ALU opcode; 5'b1_0010 = l.cust5.
REQ-004 SHALL have port: cust5_op  input  5  cust5 sub-op; 5'b00100 HEAD, 5'b01000 STORE, others ignored.
REQ-005 SHALL have port: cust5_limm  input  6  STORE word index.
REQ-006 SHALL have port: digest  input  512  squeezed SHA3-512 state from Keccak core.
REQ-007 SHALL have port: digest_valid  input  1  one-cycle pulse; digest valid this cycle.
REQ-008 SHALL have port: keccak_dataout  output  32  registered read word.
REQ-009 SHALL have port: dout_valid  output  1  one-cycle pulse qualifying keccak_dataout.
REQ-010 SHALL have port: digest_ready  output  1  high in FULL state.
REQ-011 SHALL have port: all_read  output  1  high in DRAINED state.
REQ-012 SHALL have port: rd_err  output  1  one-cycle pulse on invalid STORE.
REQ-013 SHALL have port: overrun  output  1  sticky: unread digest overwritten.

Function
REQ-014 SHALL decode STORE = (alu_op==5'b1_0010 && cust5_op==5'b01000) and HEAD = (alu_op==5'b1_0010 && cust5_op==5'b00100).
REQ-015 SHALL implement states EMPTY, FULL, DRAINED; EMPTY after reset.
REQ-016 SHALL, on digest_valid, latch digest into a 512-bit holding register, clear 16-bit read mask, enter FULL, from any state.
REQ-017 SHALL, on digest_valid while FULL, also set overrun.
REQ-018 SHALL, on HEAD without digest_valid, enter EMPTY, clear read mask and overrun; holding register unchanged.
REQ-019 SHALL give digest_valid priority over simultaneous HEAD (capture, FULL, overrun cleared).
REQ-020 SHALL, on STORE with cust5_limm[5:4]==0 in FULL or DRAINED, drive keccak_dataout = hold[32*k+31 : 32*k], k = cust5_limm[3:0], and pulse dout_valid, next cycle (latency 1).
REQ-021 SHALL, on STORE in EMPTY or with cust5_limm[5:4]!=0, drive keccak_dataout = 0, dout_valid = 0, pulse rd_err next cycle.
REQ-022 SHALL set read-mask bit k on each valid STORE; repeated reads of a word allowed and idempotent.
REQ-023 SHALL move FULL -> DRAINED the cycle the mask becomes 16'hFFFF; DRAINED still serves reads.
REQ-024 SHALL, on STORE coinciding with digest_valid, return the word from the pre-capture register (valid only if state was not EMPTY); the new digest's mask starts clear.
REQ-025 SHALL hold keccak_dataout between reads; dout_valid and rd_err are single-cycle pulses.

Reset
REQ-026 SHALL on rst asynchronously clear: holding register 0, mask 0, state EMPTY, keccak_dataout 0, dout_valid 0, digest_ready 0, all_read 0, rd_err 0, overrun 0.
REQ-027 SHALL discard any in-flight read when rst asserts mid-operation; no dout_valid pulse follows reset release.

Configuration
REQ-028 SHALL, with KECCAK_DIGEST_READER_BSWAP_EN defined, byte-reverse each selected word (byte 0 of word to keccak_dataout[31:24]).
REQ-029 SHALL, without KECCAK_DIGEST_READER_BSWAP_EN, output the selected word bit-for-bit; all other behaviour identical.

Verification
REQ-030 SHALL cover: reset, then STORE limm=6'h0F -> keccak_dataout=0, dout_valid=0, rd_err pulse, state EMPTY.
REQ-031 SHALL cover: digest_valid with digest[511:480]=32'h18f4f4bd, STORE limm=6'h0F -> next cycle keccak_dataout=32'h18f4f4bd (32'hbdf4f418 with BSWAP), dout_valid=1 one cycle.
REQ-032 SHALL cover: STORE limm=0..15 in order after capture -> digest_ready falls and all_read rises the cycle after the 16th read; repeat limm=3 in DRAINED still returns word 3.
REQ-033 SHALL cover: second digest_valid after only 4 reads -> overrun=1, digest_ready=1, mask cleared; HEAD -> overrun=0, state EMPTY.
REQ-034 SHALL cover: STORE limm=6'h1F in FULL -> rd_err pulse, keccak_dataout=0, mask unchanged.
REQ-035 SHALL cover: STORE limm=6'h00 simultaneous with new digest_valid -> old word 0 returned, new digest captured, all_read=0; rst asserted mid-read -> all outputs 0 immediately.

Source files
------------

// File: rtl/keccak_digest_reader.sv
// Buffers a squeezed SHA3-512 digest and serves it as 32-bit words to l.cust5 reads.
// Define KECCAK_DIGEST_READER_BSWAP_EN to byte-reverse each word as it is returned.
module keccak_digest_reader (
    input  logic         clk,
    input  logic         rst,
    input  logic [4:0]   alu_op,
    input  logic [4:0]   cust5_op,
    input  logic [5:0]   cust5_limm,
    input  logic [511:0] digest,
    input  logic         digest_valid,
    output logic [31:0]  keccak_dataout,
    output logic         dout_valid,
    output logic         digest_ready,
    output logic         all_read,
    output logic         rd_err,
    output logic         overrun
);

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_FULL    = 2'd1,
        S_DRAINED = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [511:0]   hold_q, hold_d;
    logic [15:0]    mask_q, mask_d;
    logic [31:0]    dataout_q, dataout_d;
    logic           dout_valid_q, dout_valid_d;
    logic           rd_err_q, rd_err_d;
    logic           overrun_q, overrun_d;

    logic           is_cust5;
    logic           store;
    logic           head;
    logic [3:0]     idx;
    logic           rd_ok;
    logic [31:0]    word_raw;
    logic [31:0]    word_sel;
    logic [15:0]    mask_set;

    // Decode the custom instruction and select the addressed word.
    always_comb begin
        is_cust5 = (alu_op == 5'b1_0010);
        store    = is_cust5 && (cust5_op == 5'b01000);
        head     = is_cust5 && (cust5_op == 5'b00100);
        idx      = cust5_limm[3:0];
        rd_ok    = store && (cust5_limm[5:4] == 2'b00) && (state_q != S_EMPTY);
        word_raw = hold_q[{idx, 5'd0} +: 32];
`ifdef KECCAK_DIGEST_READER_BSWAP_EN
        word_sel = {word_raw[7:0], word_raw[15:8], word_raw[23:16], word_raw[31:24]};
`else
        word_sel = word_raw;
`endif
        mask_set = rd_ok ? (16'h0001 << idx) : 16'h0000;
    end

    // Next-state: capture has priority over HEAD, and reads use the pre-capture data.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        mask_d       = mask_q;
        dataout_d    = dataout_q;
        dout_valid_d = 1'b0;
        rd_err_d     = 1'b0;
        overrun_d    = overrun_q;

        if (store) begin
            if (rd_ok) begin
                dataout_d    = word_sel;
                dout_valid_d = 1'b1;
            end else begin
                dataout_d = 32'h0;
                rd_err_d  = 1'b1;
            end
        end

        if (digest_valid) begin
            hold_d  = digest;
            mask_d  = 16'h0000;
            state_d = S_FULL;
            if (head) begin
                overrun_d = 1'b0;
            end else if (state_q == S_FULL) begin
                overrun_d = 1'b1;
            end
        end else if (head) begin
            state_d   = S_EMPTY;
            mask_d    = 16'h0000;
            overrun_d = 1'b0;
        end else if (rd_ok) begin
            mask_d = mask_q | mask_set;
            if ((state_q == S_FULL) && (mask_d == 16'hFFFF)) begin
                state_d = S_DRAINED;
            end
        end
    end

    // State and registered outputs; reset discards any in-flight read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_EMPTY;
            hold_q       <= '0;
            mask_q       <= '0;
            dataout_q    <= '0;
            dout_valid_q <= 1'b0;
            rd_err_q     <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            mask_q       <= mask_d;
            dataout_q    <= dataout_d;
            dout_valid_q <= dout_valid_d;
            rd_err_q     <= rd_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign keccak_dataout = dataout_q;
    assign dout_valid     = dout_valid_q;
    assign rd_err         = rd_err_q;
    assign overrun        = overrun_q;
    assign digest_ready   = (state_q == S_FULL);
    assign all_read       = (state_q == S_DRAINED);

endmodule

// File: tb/tb_keccak_digest_reader.sv
// Directed testbench for keccak_digest_reader.
// Flags are compared as {dout_valid, rd_err, digest_ready, all_read, overrun}.
module tb_keccak_digest_reader;

    logic         clk;
    logic         rst;
    logic [4:0]   alu_op;
    logic [4:0]   cust5_op;
    logic [5:0]   cust5_limm;
    logic [511:0] digest;
    logic         digest_valid;
    logic [31:0]  keccak_dataout;
    logic         dout_valid;
    logic         digest_ready;
    logic         all_read;
    logic         rd_err;
    logic         overrun;

    int errors = 0;
    int checks = 0;

    logic [511:0] dig1;
    logic [511:0] dig2;
    logic [4:0]   flags;

    keccak_digest_reader dut (
        .clk            (clk),
        .rst            (rst),
        .alu_op         (alu_op),
        .cust5_op       (cust5_op),
        .cust5_limm     (cust5_limm),
        .digest         (digest),
        .digest_valid   (digest_valid),
        .keccak_dataout (keccak_dataout),
        .dout_valid     (dout_valid),
        .digest_ready   (digest_ready),
        .all_read       (all_read),
        .rd_err         (rd_err),
        .overrun        (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign flags = {dout_valid, rd_err, digest_ready, all_read, overrun};

    function automatic logic [31:0] exp_word(input logic [511:0] d, input int k);
        logic [31:0] w;
        w = d[32*k +: 32];
`ifdef KECCAK_DIGEST_READER_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        alu_op       = 5'b0;
        cust5_op     = 5'b0;
        cust5_limm   = 6'h0;
        digest_valid = 1'b0;
    endtask

    task automatic set_store(input logic [5:0] l);
        alu_op     = 5'b1_0010;
        cust5_op   = 5'b01000;
        cust5_limm = l;
    endtask

    task automatic set_head();
        alu_op   = 5'b1_0010;
        cust5_op = 5'b00100;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        digest = '0;
        tick();
        tick();
        checks++;
        if (flags !== 5'b00000) begin
            $display("FAIL reset_flags: got %b want %b", flags, 5'b00000);
            errors++;
        end
        checks++;
        if (keccak_dataout !== 32'h0) begin
            $display("FAIL reset_data: got %h want %h", keccak_dataout, 32'h0);
            errors++;
        end
        rst = 1'b0;
        tick();
        checks++;
        if (flags !== 5'b00000) begin
            $display("FAIL post_reset_flags: got %b want %b", flags, 5'b00000);
            errors++;
        end
    endtask

    task automatic test_store_empty();
        set_store(6'h0F);
        tick();
        set_idle();
        checks++;
        if (keccak_dataout !== 32'h0) begin
            $display("FAIL empty_store_data: got %h want %h", keccak_dataout, 32'h0);
            errors++;
        end
        checks++;
        if (flags !== 5'b01000) begin
            $display("FAIL empty_store_flags: got %b want %b", flags, 5'b01000);
            errors++;
        end
        tick();
        checks++;
        if (flags !== 5'b00000) begin
            $display("FAIL empty_store_pulse: got %b want %b", flags, 5'b00000);
            errors++;
        end
    endtask

    task automatic test_capture_read();
        digest       = dig1;
        digest_valid = 1'b1;
        tick();
        digest_valid = 1'b0;
        checks++;
        if (flags !== 5'b00100) begin
            $display("FAIL capture_flags: got %b want %b", flags, 5'b00100);
            errors++;
        end
        set_store(6'h0F);
        tick();
        set_idle();
        checks++;
        if (keccak_dataout !== exp_word(dig1, 15)) begin
            $display("FAIL read15_data: got %h want %h", keccak_dataout, exp_word(dig1, 15));
            errors++;
        end
        checks++;
        if (flags !== 5'b10100) begin
            $display("FAIL read15_flags: got %b want %b", flags, 5'b10100);
            errors++;
        end
        tick();
        checks++;
        if (flags !== 5'b00100 || keccak_dataout !== exp_word(dig1, 15)) begin
            $display("FAIL read15_hold: got %b/%h want %b/%h",
                     flags, keccak_dataout, 5'b00100, exp_word(dig1, 15));
            errors++;
        end
    endtask

    task automatic test_drain();
        set_head();
        tick();
        set_idle();
        checks++;
        if (flags !== 5'b00000) begin
            $display("FAIL head_empty: got %b want %b", flags, 5'b00000);
            errors++;
        end
        digest       = dig2;
        digest_valid = 1'b1;
        tick();
        digest_valid = 1'b0;
        checks++;
        if (flags !== 5'b00100) begin
            $display("FAIL drain_capture: got %b want %b", flags, 5'b00100);
            errors++;
        end
        for (int k = 0; k < 16; k++) begin
            set_store(6'(k));
            tick();
            checks++;
            if (keccak_dataout !== exp_word(dig2, k)) begin
                $display("FAIL drain_data[%0d]: got %h want %h",
                         k, keccak_dataout, exp_word(dig2, k));
                errors++;
            end
            checks++;
            if (flags !== ((k < 15) ? 5'b10100 : 5'b10010)) begin
                $display("FAIL drain_flags[%0d]: got %b want %b",
                         k, flags, (k < 15) ? 5'b10100 : 5'b10010);
                errors++;
            end
        end
        set_store(6'h03);
        tick();
        set_idle();
        checks++;
        if (keccak_dataout !== exp_word(dig2, 3) || flags !== 5'b10010) begin
            $display("FAIL drained_reread: got %b/%h want %b/%h",
                     flags, keccak_dataout, 5'b10010, exp_word(dig2, 3));
            errors++;
        end
        tick();
        checks++;
        if (flags !== 5'b00010) begin
            $display("FAIL drained_idle: got %b want %b", flags, 5'b00010);
            errors++;
        end
    endtask

    task automatic test_overrun();
        digest       = dig1;
        digest_valid = 1'b1;
        tick();
        digest_valid = 1'b0;
        checks++;
        if (flags !== 5'b00100) begin
            $display("FAIL recapture_drained: got %b want %b", flags, 5'b00100);
            errors++;
        end
        for (int k = 0; k < 4; k++) begin
            set_store(6'(k));
            tick();
        end
        set_idle();
        digest       = dig2;
        digest_valid = 1'b1;
        tick();
        digest_valid = 1'b0;
        checks++;
        if (flags !== 5'b00101) begin
            $display("FAIL overrun_set: got %b want %b", flags, 5'b00101);
            errors++;
        end
        for (int k = 4; k < 16; k++) begin
            set_store(6'(k));
            tick();
        end
        set_idle();
        checks++;
        if (flags !== 5'b10101 || keccak_dataout !== exp_word(dig2, 15)) begin
            $display("FAIL overrun_mask_clear: got %b/%h want %b/%h",
                     flags, keccak_dataout, 5'b10101, exp_word(dig2, 15));
            errors++;
        end
        set_head();
        tick();
        set_idle();
        checks++;
        if (flags !== 5'b00000) begin
            $display("FAIL head_clears: got %b want %b", flags, 5'b00000);
            errors++;
        end
    endtask

    task automatic test_bad_index();
        digest       = dig1;
        digest_valid = 1'b1;
        tick();
        digest_valid = 1'b0;
        set_store(6'h00);
        tick();
        set_store(6'h1F);
        tick();
        set_idle();
        checks++;
        if (keccak_dataout !== 32'h0) begin
            $display("FAIL bad_idx_data: got %h want %h", keccak_dataout, 32'h0);
            errors++;
        end
        checks++;
        if (flags !== 5'b01100) begin
            $display("FAIL bad_idx_flags: got %b want %b", flags, 5'b01100);
            errors++;
        end
        for (int k = 1; k < 15; k++) begin
            set_store(6'(k));
            tick();
        end
        checks++;
        if (flags !== 5'b10100) begin
            $display("FAIL bad_idx_mask14: got %b want %b", flags, 5'b10100);
            errors++;
        end
        set_store(6'h0F);
        tick();
        set_idle();
        checks++;
        if (flags !== 5'b10010 || keccak_dataout !== exp_word(dig1, 15)) begin
            $display("FAIL bad_idx_mask16: got %b/%h want %b/%h",
                     flags, keccak_dataout, 5'b10010, exp_word(dig1, 15));
            errors++;
        end
    endtask

    task automatic test_store_with_capture();
        set_store(6'h00);
        digest       = dig2;
        digest_valid = 1'b1;
        tick();
        digest_valid = 1'b0;
        checks++;
        if (keccak_dataout !== exp_word(dig1, 0)) begin
            $display("FAIL coincide_data: got %h want %h", keccak_dataout, exp_word(dig1, 0));
            errors++;
        end
        checks++;
        if (flags !== 5'b10100) begin
            $display("FAIL coincide_flags: got %b want %b", flags, 5'b10100);
            errors++;
        end
        tick();
        checks++;
        if (keccak_dataout !== exp_word(dig2, 0) || flags !== 5'b10100) begin
            $display("FAIL coincide_new: got %b/%h want %b/%h",
                     flags, keccak_dataout, 5'b10100, exp_word(dig2, 0));
            errors++;
        end
    endtask

    task automatic test_reset_mid();
        set_store(6'h05);
        tick();
        checks++;
        if (keccak_dataout !== exp_word(dig2, 5) || flags !== 5'b10100) begin
            $display("FAIL pre_rst_read: got %b/%h want %b/%h",
                     flags, keccak_dataout, 5'b10100, exp_word(dig2, 5));
            errors++;
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (keccak_dataout !== 32'h0 || flags !== 5'b00000) begin
            $display("FAIL async_rst: got %b/%h want %b/%h",
                     flags, keccak_dataout, 5'b00000, 32'h0);
            errors++;
        end
        set_idle();
        @(posedge clk);
        #4;
        rst = 1'b0;
        tick();
        checks++;
        if (keccak_dataout !== 32'h0 || flags !== 5'b00000) begin
            $display("FAIL post_rst_release: got %b/%h want %b/%h",
                     flags, keccak_dataout, 5'b00000, 32'h0);
            errors++;
        end
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin
            dig1[32*k +: 32] = 32'hC0DE_0000 | 32'(k);
            dig2[32*k +: 32] = 32'h5A00_0000 + 32'(k) * 32'h0001_0101;
        end
        dig1[511:480] = 32'h18f4f4bd;
        test_reset();
        test_store_empty();
        test_capture_read();
        test_drain();
        test_overrun();
        test_bad_index();
        test_store_with_capture();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
